// File: rtl/mlp_dense_layer.sv
// mlp_dense_layer
// Single fully-connected layer engine. It buffers one input activation
// vector, streams bias and weights from the layer weight memory, and runs a
// signed fixed-point multiply-accumulate for each neuron. It can apply ReLU
// to each result before the result is sent out.
//
// Optional feature macro: MLP_DENSE_SAT_EN
//   defined   -> the narrowing to DATA_WIDTH saturates
//   undefined -> the narrowing truncates (two's-complement wrap)
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle layer request (sampled in IDLE only)
//   num_in, num_out   input count N and neuron count M (latched on start)
//   w_base            base address of the layer's weight block (latched)
//   relu_en           apply ReLU to outputs (latched)
//   in_valid/in_data/in_ready     input activation stream
//   w_rd_en/w_addr/w_rdata        weight memory port (read data 1 cycle later)
//   out_valid/out_data/out_ready  neuron result stream
//   busy              high outside IDLE
//   cfg_err           one-cycle pulse after an illegal start
//   done              pulse in the cycle the last result is accepted
//
// Handshake semantics, used for both streams: a beat transfers on a rising
// clk edge where valid && ready are both high. The producer holds valid and
// data stable until that edge. Ready never depends on valid.
module mlp_dense_layer #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_WIDTH  = 40,
  parameter int MAX_IN     = 64,
  parameter int CNT_WIDTH  = 7,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_in,
  input  logic [CNT_WIDTH-1:0]  num_out,
  input  logic [ADDR_WIDTH-1:0] w_base,
  input  logic                  relu_en,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  w_rd_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_rdata,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  cfg_err,
  output logic                  done
);

  localparam int XW = $clog2(MAX_IN);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_BIAS, S_MAC, S_DRAIN, S_EMIT
  } state_t;

  state_t state, state_next;

  logic [CNT_WIDTH-1:0]  n_r, m_r, k_r, j_r;
  logic [XW-1:0]         rd_k_d;
  logic                  relu_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  bias_d, wt_d;   // kind of read issued last cycle
  logic                  cfg_err_r;
  logic [DATA_WIDTH-1:0] out_data_r;

  logic signed [ACC_WIDTH-1:0]    acc, acc_next;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [DATA_WIDTH-1:0]   x_mem [MAX_IN];
  logic [DATA_WIDTH-1:0]          narrowed, result;

  logic cfg_bad, last_k, last_j;

  assign cfg_bad = (num_in == '0) || (num_out == '0) || (int'(num_in) > MAX_IN);
  assign last_k  = (k_r == n_r - CNT_WIDTH'(1));
  assign last_j  = (j_r == m_r - CNT_WIDTH'(1));

  // Read data returns one cycle after issue. The pipelined read kind and
  // index therefore decide what the data on w_rdata means this cycle.
  assign prod = $signed(w_rdata) * x_mem[rd_k_d];

  always_comb begin
    acc_next = acc;
    if (bias_d) begin
      acc_next = $signed({{(ACC_WIDTH-DATA_WIDTH){w_rdata[DATA_WIDTH-1]}}, w_rdata}) <<< FRAC_BITS;
    end else if (wt_d) begin
      acc_next = acc + $signed({{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod});
    end
  end

`ifdef MLP_DENSE_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  logic signed [ACC_WIDTH-1:0] shifted;
  always_comb begin
    shifted = acc_next >>> FRAC_BITS;
    if (shifted > SAT_MAX)      narrowed = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (shifted < SAT_MIN) narrowed = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                        narrowed = shifted[DATA_WIDTH-1:0];
  end
`else
  // The arithmetic shift followed by a truncation keeps only these bits.
  assign narrowed = acc_next[FRAC_BITS +: DATA_WIDTH];
`endif

  assign result = (relu_r && narrowed[DATA_WIDTH-1]) ? '0 : narrowed;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next state and outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    w_rd_en    = 1'b0;
    out_valid  = 1'b0;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    case (state)
      S_IDLE:  if (start && !cfg_bad) state_next = S_LOAD;
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && last_k) state_next = S_BIAS;
      end
      S_BIAS: begin
        w_rd_en    = 1'b1;
        state_next = S_MAC;
      end
      S_MAC: begin
        w_rd_en = 1'b1;
        if (last_k) state_next = S_DRAIN;
      end
      S_DRAIN: state_next = S_EMIT;
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          done       = last_j;
          state_next = last_j ? S_IDLE : S_BIAS;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign w_addr   = addr_r;
  assign out_data = out_data_r;
  assign cfg_err  = cfg_err_r;

  // Datapath and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_r        <= '0;
      m_r        <= '0;
      k_r        <= '0;
      j_r        <= '0;
      rd_k_d     <= '0;
      relu_r     <= 1'b0;
      addr_r     <= '0;
      bias_d     <= 1'b0;
      wt_d       <= 1'b0;
      cfg_err_r  <= 1'b0;
      out_data_r <= '0;
      acc        <= '0;
    end else begin
      cfg_err_r <= (state == S_IDLE) && start && cfg_bad;
      bias_d    <= (state == S_BIAS);
      wt_d      <= (state == S_MAC);
      rd_k_d    <= k_r[XW-1:0];
      acc       <= acc_next;
      case (state)
        S_IDLE: if (start && !cfg_bad) begin
          n_r    <= num_in;
          m_r    <= num_out;
          relu_r <= relu_en;
          addr_r <= w_base;
          k_r    <= '0;
          j_r    <= '0;
        end
        S_LOAD: if (in_valid) k_r <= k_r + CNT_WIDTH'(1);
        S_BIAS: begin
          addr_r <= addr_r + ADDR_WIDTH'(1);
          k_r    <= '0;
        end
        S_MAC: begin
          addr_r <= addr_r + ADDR_WIDTH'(1);
          k_r    <= k_r + CNT_WIDTH'(1);
        end
        S_DRAIN: out_data_r <= result;
        S_EMIT:  if (out_ready && !last_j) j_r <= j_r + CNT_WIDTH'(1);
        default: ;
      endcase
    end
  end

  // Input vector buffer; it is reloaded on every layer, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && in_valid) x_mem[k_r[XW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_mlp_dense_layer.sv
// Self-checking bench for mlp_dense_layer: reset state, the fixed-point
// layer function, ReLU, narrowing, output stalls, config errors, an abort by
// reset in the middle of a layer, and back-to-back neurons.
module tb_mlp_dense_layer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  num_in = '0;
  logic [6:0]  num_out = '0;
  logic [15:0] w_base = '0;
  logic        relu_en = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        w_rd_en;
  logic [15:0] w_addr;
  logic [15:0] w_rdata = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        cfg_err;
  logic        done;

  logic [15:0] mem [0:65535];
  logic [15:0] x_v [0:63];
  logic [15:0] exp_q[$];
  logic [15:0] addr_log[$];
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  mlp_dense_layer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_in(num_in),
    .num_out(num_out), .w_base(w_base), .relu_en(relu_en),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .cfg_err(cfg_err), .done(done)
  );

  // Clock / memory model / monitors
  always #5 clk = ~clk;

  always @(posedge clk) if (w_rd_en === 1'b1) w_rdata <= mem[w_addr];
  always @(negedge clk) if (w_rd_en === 1'b1) addr_log.push_back(w_addr);
  always @(posedge clk) if (done === 1'b1) done_cnt++;

  // Reference model of one neuron
  function automatic logic [15:0] model(int base, int n, int j, bit relu);
    longint acc, sh;
    logic [15:0] res;
    int a;
    a = base + j * (n + 1);
    acc = longint'($signed(mem[a[15:0]])) * 256;
    for (int k = 0; k < n; k++) begin
      a = base + j * (n + 1) + 1 + k;
      acc += longint'($signed(mem[a[15:0]])) * longint'($signed(x_v[k]));
    end
    sh = acc >>> 8;
`ifdef MLP_DENSE_SAT_EN
    if (sh > 32767) sh = 32767;
    else if (sh < -32768) sh = -32768;
`endif
    res = sh[15:0];
    if (relu && res[15]) res = '0;
    return res;
  endfunction

  // Driver tasks
  task automatic drive_start(input int n, input int m, input int base, input bit relu);
    @(negedge clk);
    start = 1'b1; num_in = 7'(n); num_out = 7'(m); w_base = 16'(base); relu_en = relu;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Ends at the first negedge of the BIAS cycle.
  task automatic drive_inputs(input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 1)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1; in_data = x_v[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic accept(output bit d);
    out_ready = 1'b1;
    #1 d = done;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic fill_random(input int base, input int cnt, input int n);
    for (int i = 0; i < cnt; i++) mem[16'(base + i)] = 16'($urandom_range(0, 65535));
    for (int k = 0; k < n; k++) x_v[k] = 16'($urandom_range(0, 65535));
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, w_rd_en, w_addr, out_valid, out_data, busy, cfg_err, done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %0h expected 0",
               {in_ready, w_rd_en, w_addr, out_valid, out_data, busy, cfg_err, done});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic(input string tag);
    int cyc, d0;
    bit d;
    logic [15:0] e;
    mem[100] = 16'd128; mem[101] = 16'd256; mem[102] = 16'hFF80;
    x_v[0] = 16'd256; x_v[1] = 16'd512;
    exp_q.push_back(16'd128);
    d0 = done_cnt;
    drive_start(2, 1, 100, 1'b0);
    drive_inputs(2);
    wait_valid(cyc);
    checks++;
    if (cyc != 4) begin
      failures++;
      $display("FAIL %s_latency: got %0d expected 4", tag, cyc);
    end
    e = exp_q.pop_front();
    checks++;
    if (out_data !== e) begin
      failures++;
      $display("FAIL %s_data: got %0h expected %0h", tag, out_data, e);
    end
    accept(d);
    checks++;
    if (d !== 1'b1 || busy !== 1'b0 || done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL %s_done: got done=%0b busy=%0b pulses=%0d expected 1 0 1",
               tag, d, busy, done_cnt - d0);
    end
  endtask

  task automatic test_relu();
    int cyc;
    bit d;
    logic [15:0] e;
    mem[200] = 16'hFF00; mem[201] = 16'h0000;
    x_v[0] = 16'($urandom_range(0, 65535));
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(r == 0 ? 16'h0000 : 16'hFF00);
      drive_start(1, 1, 200, r == 0);
      drive_inputs(1);
      wait_valid(cyc);
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_data !== e) begin
        failures++;
        $display("FAIL relu_%0d: got valid=%0b data=%0h expected %0h", r, out_valid, out_data, e);
      end
      accept(d);
    end
  endtask

  task automatic test_narrow();
    int cyc;
    bit d;
    logic [15:0] e;
    mem[400] = 16'h0000; mem[401] = 16'h7FFF;
    x_v[0] = 16'h7FFF;
`ifdef MLP_DENSE_SAT_EN
    exp_q.push_back(16'h7FFF);
`else
    exp_q.push_back(16'hFF00);
`endif
    drive_start(1, 1, 400, 1'b0);
    drive_inputs(1);
    wait_valid(cyc);
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_data !== e) begin
      failures++;
      $display("FAIL narrow: got valid=%0b data=%0h expected %0h", out_valid, out_data, e);
    end
    accept(d);
  endtask

  task automatic test_stall();
    int cyc, d0;
    bit d;
    logic [15:0] e, held;
    fill_random(32'hFFFA, 12, 3);
    for (int j = 0; j < 3; j++) exp_q.push_back(model(32'hFFFA, 3, j, 1'b0));
    addr_log.delete();
    d0 = done_cnt;
    drive_start(3, 3, 32'hFFFA, 1'b0);
    drive_inputs(3);
    for (int j = 0; j < 3; j++) begin
      wait_valid(cyc);
      held = out_data;
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || held !== e) begin
        failures++;
        $display("FAIL stall_data_%0d: got valid=%0b data=%0h expected %0h", j, out_valid, held, e);
      end
      repeat (5) begin
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== held || w_rd_en !== 1'b0) begin
          failures++;
          $display("FAIL stall_hold_%0d: got valid=%0b data=%0h rd=%0b expected 1 %0h 0",
                   j, out_valid, out_data, w_rd_en, held);
        end
      end
      accept(d);
      checks++;
      if (d !== (j == 2)) begin
        failures++;
        $display("FAIL stall_done_%0d: got %0b expected %0b", j, d, j == 2);
      end
    end
    checks++;
    if (addr_log.size() != 12) begin
      failures++;
      $display("FAIL stall_addr_count: got %0d expected 12", addr_log.size());
    end
    for (int i = 0; i < addr_log.size() && i < 12; i++) begin
      checks++;
      if (addr_log[i] !== 16'(32'hFFFA + i)) begin
        failures++;
        $display("FAIL stall_addr_%0d: got %0h expected %0h", i, addr_log[i], 16'(32'hFFFA + i));
      end
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL stall_done_count: got %0d expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_cfg_err();
    int n0;
    int bad_n[3] = '{0, 65, 1};
    int bad_m[3] = '{1, 1, 0};
    for (int c = 0; c < 3; c++) begin
      n0 = addr_log.size();
      drive_start(bad_n[c], bad_m[c], 500, 1'b0);
      checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL cfg_err_pulse_%0d: got err=%0b busy=%0b expected 1 0", c, cfg_err, busy);
      end
      @(negedge clk);
      checks++;
      if (cfg_err !== 1'b0 || busy !== 1'b0 || addr_log.size() != n0) begin
        failures++;
        $display("FAIL cfg_err_after_%0d: got err=%0b busy=%0b reads=%0d expected 0 0 0",
                 c, cfg_err, busy, addr_log.size() - n0);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, d0;
    bit d;
    logic [15:0] e;
    fill_random(300, 8, 3);
    exp_q.push_back(model(300, 3, 0, 1'b0));
    drive_start(3, 2, 300, 1'b0);
    drive_inputs(3);
    wait_valid(cyc);
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_data !== e) begin
      failures++;
      $display("FAIL abort_first: got valid=%0b data=%0h expected %0h", out_valid, out_data, e);
    end
    accept(d);
    d0 = done_cnt;
    @(negedge clk);   // neuron 1 is now in MAC
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, w_rd_en, w_addr, out_valid, out_data, busy, cfg_err, done} !== '0) begin
      failures++;
      $display("FAIL abort_outputs: got %0h expected 0",
               {in_ready, w_rd_en, w_addr, out_valid, out_data, busy, cfg_err, done});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done: got pulses=%0d busy=%0b expected 0 0", done_cnt - d0, busy);
    end
    test_basic("after_abort");
  endtask

  task automatic test_back_to_back();
    int cfg_n[3] = '{5, 64, 1};
    int cfg_m[3] = '{3, 1, 4};
    int cyc, base, n, m;
    bit d;
    logic [15:0] e;
    for (int c = 0; c < 3; c++) begin
      n = cfg_n[c]; m = cfg_m[c];
      base = $urandom_range(0, 65535);
      fill_random(base, m * (n + 1), n);
      for (int j = 0; j < m; j++) exp_q.push_back(model(base, n, j, 1'b1));
      drive_start(n, m, base, 1'b1);
      drive_inputs(n);
      out_ready = 1'b1;
      for (int j = 0; j < m; j++) begin
        wait_valid(cyc);
        #1 d = done;
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== e || cyc != n + 2 || d !== (j == m - 1)) begin
          failures++;
          $display("FAIL b2b_%0d_%0d: got valid=%0b data=%0h gap=%0d done=%0b expected %0h %0d %0b",
                   c, j, out_valid, out_data, cyc, d, e, n + 2, j == m - 1);
        end
        @(negedge clk);
      end
      out_ready = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL b2b_%0d_idle: got busy=%0b expected 0", c, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_relu();
    test_narrow();
    test_stall();
    test_cfg_err();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
